rcv_sequencer: RTL and testbench
================================

# rcv_sequencer

Receive-side control unit for the serial receiver. It synchronizes the raw serial line, detects and qualifies the start bit, and times each bit period. It issues single-cycle `shift_enable` pulses to the LSB-first receive shift register at mid-bit, checks the stop bit, and manages the `data_ready`, framing-error and overrun status seen by the host.

## Interface
- `CLKS_PER_BIT`, 10: clock cycles per serial bit (C); legal range 4..255.
- `NUM_DATA_BITS`, 8: data bits per frame (N); legal range 1..16.
- `clk` in 1: single system clock; all state on rising edge.
- `n_rst` in 1: reset, asynchronous, active-low; one clock domain.
- `serial_in` in 1: raw asynchronous serial line, idle high.
- `data_read` in 1: host has consumed the received byte; level-sampled each cycle.
- `shift_enable` out 1: one-cycle pulse; the shift register captures `serial_in` on it.
- `load_buffer` out 1: one-cycle pulse; the receive buffer captures the shift register contents.
- `data_ready` out 1: a received byte is waiting in the buffer.
- `framing_error` out 1: the last frame had a stop bit of 0.
- `overrun_error` out 1: a new byte was loaded while `data_ready` was still set.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **Synchronizer**
  - Two flops on `serial_in`, both reset to 1. Call the synchronized value `rx`.
  - A third flop holds the previous `rx`.
  - Start edge: previous `rx` = 1 and `rx` = 0.
- **Counters**
  - Bit-period counter: width clog2(C). Cleared on every state entry and when it wraps within DATA.
  - Bit counter: width clog2(N+1). Cleared on entry to DATA.
- **FSM**
  - IDLE
    - Wait for a start edge, then go to START.
    - `framing_error` clears on start-edge detection.
  - START
    - On the H-th cycle in START (H = C/2, floor), sample `rx`.
    - `rx` = 0: go to DATA.
    - `rx` = 1: false start; go to IDLE with no other effect.
  - DATA
    - On the C-th cycle of each bit period, assert `shift_enable` and increment the bit counter.
    - After the N-th pulse, go to STOP.
  - STOP
    - On the C-th cycle, sample `rx`.
    - `rx` = 1: go to LOAD.
    - `rx` = 0: set `framing_error`, go to IDLE, and do not load.
  - LOAD
    - Single cycle. Assert `load_buffer`; the next state is IDLE.
    - `overrun_error` sets if `data_ready` = 1 and `data_read` = 0 in this cycle.
    - `data_ready` is 1 from the next cycle.
- **Status rules**
  - `data_read` = 1 clears `data_ready` and `overrun_error` on the next edge, except in the LOAD cycle.
  - In the LOAD cycle with `data_read` = 1, the old byte counts as consumed: `data_ready` stays 1 and `overrun_error` does not set.
  - `framing_error` holds until the next start edge or reset.
- **Line activity outside IDLE**: start edges are ignored; `rx` is only sampled at the defined points.

## Timing
- **Reset**
  - `shift_enable`, `load_buffer`, `data_ready`, `framing_error`, `overrun_error` and `busy` are all 0.
  - State is IDLE, counters are 0, synchronizer flops are 1.
- **Edge detection**: a raw falling edge sampled at edge T is detected at cycle T+2 (E). START is entered at S = E+1, and `busy` = 1 from S.
- **Frame schedule** (relative to S)
  - Start sample: S+H-1.
  - DATA entered: S+H.
  - `shift_enable` pulses: S+H+k·C-1, for k = 1..N.
  - STOP entered: S+H+N·C.
  - Stop sample: S+H+(N+1)·C-1.
  - LOAD: S+H+(N+1)·C; `data_ready` rises the cycle after.
- **C=10, N=8 example**
  - Shifts at S+14, 24, …, 84.
  - Stop sample at S+94.
  - `load_buffer` at S+95.
  - `data_ready` = 1 at S+96.
  - `busy` = 0 at S+96.
- **Back-to-back frames**: a new start edge is accepted in the first IDLE cycle after LOAD or after a framing error.
- **Reset mid-frame**: all outputs return to reset values immediately, with no `load_buffer` and no status change afterward. The shift register contents are don't-care.

## Test plan
- **Reset**: assert `n_rst` = 0 mid-DATA (after 3 shifts) → all outputs 0 at once; no pulses after release while the line idles high.
- **Nominal frame**: C=10, N=8, frame 0x A5 sent LSB first, stop bit 1 → 8 `shift_enable` pulses at S+14..S+84 in 10-cycle steps; `load_buffer` at S+95; `data_ready` = 1 at S+96; `framing_error` = 0.
- **False start**: line low for 3 cycles, then high → FSM returns to IDLE at S+5; no `shift_enable`; `busy` low again.
- **Framing error**: stop bit 0 → `framing_error` = 1 at S+95; no `load_buffer`; `data_ready` unchanged; `framing_error` clears on the next start edge.
- **Overrun**: two frames with no `data_read` → second `load_buffer` sets `overrun_error` = 1; `data_read` pulse clears both `data_ready` and `overrun_error`.
- **Simultaneous read and load**: `data_read` = 1 in the LOAD cycle of the second frame → `data_ready` stays 1, `overrun_error` stays 0.

Source files
------------

// File: rtl/rcv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : rcv_sequencer_if
// Desc   : Serial line, host read strobe and receive-control status bundle.
// Rev    : 1.0
// ============================================================================
interface rcv_sequencer_if;
    logic serial_in;
    logic data_read;
    logic shift_enable;
    logic load_buffer;
    logic data_ready;
    logic framing_error;
    logic overrun_error;
    logic busy;

    modport master (
        output serial_in,
        output data_read,
        input  shift_enable,
        input  load_buffer,
        input  data_ready,
        input  framing_error,
        input  overrun_error,
        input  busy
    );

    modport slave (
        input  serial_in,
        input  data_read,
        output shift_enable,
        output load_buffer,
        output data_ready,
        output framing_error,
        output overrun_error,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/rcv_sequencer.sv
`default_nettype none
// ============================================================================
// Module : rcv_sequencer
// Desc   : Serial receive control: line sync, start qualify, mid-bit shift
//          strobes, stop check and host status flags.
// Rev    : 1.0
// ============================================================================
module rcv_sequencer #(
    parameter int CLKS_PER_BIT  = 10,
    parameter int NUM_DATA_BITS = 8
) (
    input  logic           clk,
    input  logic           n_rst,
    rcv_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(NUM_DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PERIOD_PRE = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(NUM_DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        LOAD  = 3'd4
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               sync_meta;
    logic               rx;
    logic               rx_prev;
    logic               shift_q;
    logic               load_q;
    logic               ready_q;
    logic               frame_err_q;
    logic               overrun_q;
    logic               busy_q;
    logic               start_edge;

    assign start_edge = rx_prev & ~rx;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            sync_meta   <= 1'b1;
            rx          <= 1'b1;
            rx_prev     <= 1'b1;
            shift_q     <= 1'b0;
            load_q      <= 1'b0;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync_meta <= bus.serial_in;
            rx        <= sync_meta;
            rx_prev   <= rx;
            shift_q   <= 1'b0;
            load_q    <= 1'b0;

            // A read during LOAD consumes the old byte; the new one stays pending.
            if (bus.data_read && (state != LOAD)) begin
                ready_q   <= 1'b0;
                overrun_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state       <= START;
                        cnt         <= '0;
                        frame_err_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    // Registered strobe: raise one cycle early so it lands on the last count.
                    if (cnt == PERIOD_PRE) begin
                        shift_q <= 1'b1;
                    end
                    if (cnt == PERIOD_LAST) begin
                        cnt     <= '0;
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        if (bit_cnt == DATA_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (cnt == PERIOD_LAST) begin
                        cnt <= '0;
                        if (rx) begin
                            state  <= LOAD;
                            load_q <= 1'b1;
                        end else begin
                            state       <= IDLE;
                            frame_err_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                LOAD: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    if (ready_q && !bus.data_read) begin
                        overrun_q <= 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.shift_enable  = shift_q;
    assign bus.load_buffer   = load_q;
    assign bus.data_ready    = ready_q;
    assign bus.framing_error = frame_err_q;
    assign bus.overrun_error = overrun_q;
    assign bus.busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_rcv_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_rcv_sequencer
// Desc   : Self-checking bench: frame-level reference schedule, table, directed and random frames.
// Rev    : 1.0
// ============================================================================
module tb_rcv_sequencer;
    localparam int C      = 10;
    localparam int N      = 8;
    localparam int H      = C / 2;
    localparam int MAXLEN = 4096;

    typedef struct {
        logic [7:0] data;
        bit         stop_bit;
        bit         rd_in_load;
        bit         rd_after;
        bit         exp_dr;
        bit         exp_fe;
        bit         exp_ov;
    } vec_t;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    rcv_sequencer_if bus ();

    rcv_sequencer #(
        .CLKS_PER_BIT  (C),
        .NUM_DATA_BITS (N)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    bit         line     [MAXLEN];
    bit         rd       [MAXLEN];
    bit         e_shift  [MAXLEN];
    bit         e_load   [MAXLEN];
    bit         e_busy   [MAXLEN];
    bit         e_fe_set [MAXLEN];
    bit         e_fe_clr [MAXLEN];
    logic [5:0] e_out    [MAXLEN];
    logic [5:0] act      [MAXLEN];
    int         len;
    logic [15:0] byte_q  [$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bus.shift_enable, bus.load_buffer, bus.busy,
                bus.data_ready, bus.framing_error, bus.overrun_error};
    endfunction

    function automatic void begin_scenario();
        len = 0;
        byte_q.delete();
        for (int i = 0; i < MAXLEN; i++) rd[i] = 1'b0;
    endfunction

    function automatic void put(bit v, int cycles);
        for (int i = 0; i < cycles; i++) begin
            if (len < MAXLEN) begin
                line[len] = v;
                len++;
            end
        end
    endfunction

    function automatic void put_frame(logic [15:0] d, bit stop, int stop_len);
        put(1'b0, C);
        for (int i = 0; i < N; i++) put(d[i], C);
        put(stop, stop_len);
        if (stop) byte_q.push_back(d & ((16'h1 << N) - 16'h1));
    endfunction

    // Synchronised line as seen by the receiver: two register stages behind the pin.
    function automatic bit rxv(int t);
        if (t < 2 || t - 2 >= len) return 1'b1;
        return line[t-2];
    endfunction

    function automatic void mark_busy(int a, int b);
        for (int i = a; i <= b && i < len; i++) e_busy[i] = 1'b1;
    endfunction

    // Frame-level schedule: find each qualified start, then place events by arithmetic.
    function automatic void run_model();
        int t, s, ss, sp;
        bit dr, ov, fe;
        for (int i = 0; i < MAXLEN; i++) begin
            e_shift[i] = 1'b0; e_load[i] = 1'b0; e_busy[i] = 1'b0;
            e_fe_set[i] = 1'b0; e_fe_clr[i] = 1'b0;
        end
        t = 1;
        while (t < len) begin
            if (rxv(t - 1) && !rxv(t)) begin
                s  = t + 1;
                ss = s + H - 1;
                e_fe_clr[t] = 1'b1;
                if (rxv(ss)) begin
                    mark_busy(s, ss);
                    t = ss + 1;
                end else begin
                    sp = s + H + (N + 1) * C - 1;
                    for (int k = 1; k <= N; k++)
                        if (s + H + k * C - 1 < len) e_shift[s + H + k * C - 1] = 1'b1;
                    if (rxv(sp)) begin
                        mark_busy(s, sp + 1);
                        if (sp + 1 < len) e_load[sp + 1] = 1'b1;
                        t = sp + 2;
                    end else begin
                        mark_busy(s, sp);
                        if (sp < len) e_fe_set[sp] = 1'b1;
                        t = sp + 1;
                    end
                end
            end else begin
                t++;
            end
        end
        dr = 1'b0; ov = 1'b0; fe = 1'b0;
        for (int i = 0; i < len; i++) begin
            e_out[i] = {e_shift[i], e_load[i], e_busy[i], dr, fe, ov};
            if (e_load[i]) begin
                ov = ov | (dr & ~rd[i]);
                dr = 1'b1;
            end else if (rd[i]) begin
                dr = 1'b0;
                ov = 1'b0;
            end
            if (e_fe_set[i]) fe = 1'b1;
            else if (e_fe_clr[i]) fe = 1'b0;
        end
    endfunction

    task automatic run_scenario(input string tag);
        logic [15:0] shreg;
        logic [15:0] want;
        run_model();
        n_rst         = 1'b0;
        bus.serial_in = 1'b1;
        bus.data_read = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, " reset outputs"}, 32'(outs()), 32'd0);
        n_rst = 1'b1;
        shreg = '0;
        for (int t = 0; t < len; t++) begin
            @(posedge clk);
            #1;
            bus.serial_in = line[t];
            bus.data_read = rd[t];
            @(negedge clk);
            act[t] = outs();
            check($sformatf("%s cycle %0d {shift,load,busy,rdy,fe,ov}", tag, t),
                  32'(act[t]), 32'(e_out[t]));
            if (act[t][5] && t >= 2) shreg = {line[t-2], shreg[15:1]};
            if (act[t][4]) begin
                if (byte_q.size() > 0) begin
                    want = byte_q.pop_front();
                    check($sformatf("%s cycle %0d captured byte", tag, t),
                          32'(shreg >> (16 - N)), 32'(want));
                end else begin
                    check($sformatf("%s cycle %0d unexpected load", tag, t), 32'd1, 32'd0);
                end
            end
        end
    endtask

    function automatic int count_bit(int pos, int a, int b);
        int n = 0;
        for (int i = a; i < b; i++) if (act[i][pos]) n++;
        return n;
    endfunction

    vec_t tbl [9];
    int   cp  [9];

    initial begin
        int p, p2, s, kind, stop_len, gap;
        logic [5:0] acc;
        bit stop;

        bus.serial_in = 1'b1;
        bus.data_read = 1'b0;

        // ---------------- nominal frame 0xA5 ----------------
        begin_scenario();
        put(1'b1, 4);
        p = len;
        put_frame(16'h00A5, 1'b1, C);
        put(1'b1, 10);
        run_scenario("nominal");
        s = p + 3;
        check("nominal busy before S", 32'(act[s-1][3]), 32'd0);
        check("nominal busy at S", 32'(act[s][3]), 32'd1);
        for (int k = 0; k < N; k++)
            check($sformatf("nominal shift at S+%0d", 14 + 10 * k), 32'(act[s + 14 + 10 * k][5]), 32'd1);
        check("nominal shift count", 32'(count_bit(5, 0, len)), 32'd8);
        check("nominal load at S+95", 32'(act[s+95][4]), 32'd1);
        check("nominal ready at S+96", 32'(act[s+96][2]), 32'd1);
        check("nominal busy at S+96", 32'(act[s+96][3]), 32'd0);
        check("nominal framing at S+96", 32'(act[s+96][1]), 32'd0);

        // ---------------- false start ----------------
        begin_scenario();
        put(1'b1, 4);
        put(1'b0, 3);
        put(1'b1, 20);
        run_scenario("false_start");
        s = 7;
        check("false_start busy at S+4", 32'(act[s+4][3]), 32'd1);
        check("false_start busy at S+5", 32'(act[s+5][3]), 32'd0);
        check("false_start shift count", 32'(count_bit(5, 0, len)), 32'd0);

        // ---------------- framing error then recovery ----------------
        begin_scenario();
        put(1'b1, 4);
        put_frame(16'h003C, 1'b0, C);
        put(1'b1, 6);
        p2 = len;
        put_frame(16'h0099, 1'b1, C);
        put(1'b1, 10);
        run_scenario("framing");
        s = 7;
        check("framing fe at S+95", 32'(act[s+95][1]), 32'd1);
        check("framing no load first frame", 32'(count_bit(4, 0, p2)), 32'd0);
        check("framing ready unchanged", 32'(act[s+96][2]), 32'd0);
        check("framing fe held to next edge", 32'(act[p2+2][1]), 32'd1);
        check("framing fe cleared by edge", 32'(act[p2+3][1]), 32'd0);

        // ---------------- table: status rules across frames ----------------
        tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{8'h7E, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{8'h12, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        begin_scenario();
        put(1'b1, 4);
        for (int i = 0; i < 9; i++) begin
            p = len;
            put_frame({8'h00, tbl[i].data}, tbl[i].stop_bit, C);
            put(1'b1, 8);
            if (tbl[i].rd_in_load) rd[p + 3 + H + (N + 1) * C] = 1'b1;
            if (tbl[i].rd_after)   rd[p + (N + 2) * C + 1] = 1'b1;
            cp[i] = len - 1;
        end
        run_scenario("table");
        for (int i = 0; i < 9; i++)
            check($sformatf("table[%0d] {rdy,fe,ov}", i), 32'(act[cp[i]][2:0]),
                  32'({tbl[i].exp_dr, tbl[i].exp_fe, tbl[i].exp_ov}));

        // ---------------- reset mid-DATA after three shifts ----------------
        begin_scenario();
        put(1'b1, 4);
        put_frame(16'h00A5, 1'b1, C);
        len = 42;
        byte_q.delete();
        run_scenario("reset_pre");
        check("reset three shifts before reset", 32'(count_bit(5, 0, len)), 32'd3);
        @(posedge clk);
        #3;
        n_rst         = 1'b0;
        bus.serial_in = 1'b1;
        #1;
        check("reset outputs immediately", 32'(outs()), 32'd0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        acc = '0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            acc = acc | outs();
        end
        check("reset quiet after release", 32'(acc), 32'd0);

        // ---------------- randomized frames vs schedule model ----------------
        for (int r = 0; r < 4; r++) begin
            begin_scenario();
            put(1'b1, 3);
            for (int e = 0; e < 12; e++) begin
                kind = int'($urandom_range(0, 9));
                if (kind < 2) begin
                    put(1'b0, int'($urandom_range(1, H)));
                    put(1'b1, int'($urandom_range(H + 1, 12)));
                end else begin
                    stop = ($urandom_range(0, 5) != 0);
                    if (stop) begin
                        stop_len = int'($urandom_range(H + 1, C));
                        gap = (H + 2 - stop_len > 0) ? H + 2 - stop_len : 0;
                        gap = int'($urandom_range(gap, gap + 3));
                    end else begin
                        stop_len = C;
                        gap = int'($urandom_range(1, 4));
                    end
                    put_frame(16'($urandom), stop, stop_len);
                    put(1'b1, gap);
                end
            end
            put(1'b1, 12);
            for (int i = 0; i < len; i++)
                if ($urandom_range(0, 24) == 0) rd[i] = 1'b1;
            run_scenario($sformatf("random%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation time limit, expected completion");
        $fatal(1, "bench did not complete in time");
    end

endmodule
`default_nettype wire
